seq_update_engine: RTL and testbench

Multi-cycle engine that evaluates the four-variable update set a=b+c, d=a+c, b=a-3, c=b+10 with blocking-order semantics. It executes one statement per clock, so each statement sees the results of the statements before it in the same pass. It is the sequential counterpart of the team's concurrent (nonblocking) update register bank and serves as its golden-order reference in lab benches. A start/done handshake loads the initial values and reports completion after a programmable number of passes.

---
 rtl/seq_update_engine.sv | 138 +++++++++++++
 tb/tb_seq_update_engine.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_update_engine.sv
// Multi-cycle blocking-order evaluator of a=b+c, d=a+c, b=a-3, c=b+10, one statement per clock.
// Optional SEQ_UPD_CONCURRENT_EN adds a mode input selecting a one-edge nonblocking pass.
module seq_update_engine #(
  parameter int W      = 32,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      init_a,
  input  logic [W-1:0]      init_b,
  input  logic [W-1:0]      init_c,
  input  logic [W-1:0]      init_d,
  input  logic [ITER_W-1:0] iters,
`ifdef SEQ_UPD_CONCURRENT_EN
  input  logic              mode,
`endif
  output logic [W-1:0]      a,
  output logic [W-1:0]      b,
  output logic [W-1:0]      c,
  output logic [W-1:0]      d,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] pass_cnt
);

  typedef enum logic [2:0] {IDLE, S_A, S_D, S_B, S_C, DONE} state_t;

  state_t              state_q, state_d;
  logic [W-1:0]        a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [ITER_W-1:0]   iters_q, iters_d;
  logic [ITER_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [ITER_W-1:0]   pass_inc;
  logic                conc_mode;

`ifdef SEQ_UPD_CONCURRENT_EN
  logic conc_q, conc_d;
  assign conc_mode = conc_q;
`else
  assign conc_mode = 1'b0;
`endif

  assign pass_inc = pass_cnt_q + ITER_W'(1);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    d_d        = d_q;
    iters_d    = iters_q;
    pass_cnt_d = pass_cnt_q;
`ifdef SEQ_UPD_CONCURRENT_EN
    conc_d     = conc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = init_a;
          b_d        = init_b;
          c_d        = init_c;
          d_d        = init_d;
          iters_d    = iters;
          pass_cnt_d = '0;
`ifdef SEQ_UPD_CONCURRENT_EN
          conc_d     = mode;
`endif
          state_d    = (iters != '0) ? S_A : DONE;
        end
      end
      S_A: begin
        if (conc_mode) begin
          // All four updates read the pre-edge values.
          a_d        = b_q + c_q;
          d_d        = a_q + c_q;
          b_d        = a_q - W'(3);
          c_d        = b_q + W'(10);
          pass_cnt_d = pass_inc;
          state_d    = (pass_inc < iters_q) ? S_A : DONE;
        end else begin
          a_d     = b_q + c_q;
          state_d = S_D;
        end
      end
      S_D: begin
        d_d     = a_q + c_q;
        state_d = S_B;
      end
      S_B: begin
        b_d     = a_q - W'(3);
        state_d = S_C;
      end
      S_C: begin
        c_d        = b_q + W'(10);
        pass_cnt_d = pass_inc;
        state_d    = (pass_inc < iters_q) ? S_A : DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      iters_q    <= '0;
      pass_cnt_q <= '0;
`ifdef SEQ_UPD_CONCURRENT_EN
      conc_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      iters_q    <= iters_d;
      pass_cnt_q <= pass_cnt_d;
`ifdef SEQ_UPD_CONCURRENT_EN
      conc_q     <= conc_d;
`endif
    end
  end

  // Status is decoded from the state register only, so no input reaches an output combinationally.
  assign busy     = (state_q == S_A) || (state_q == S_D) || (state_q == S_B) || (state_q == S_C);
  assign done     = (state_q == DONE);
  assign a        = a_q;
  assign b        = b_q;
  assign c        = c_q;
  assign d        = d_q;
  assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_seq_update_engine.sv
// Scoreboard bench for seq_update_engine: a W=32 instance and a W=8 instance sharing clk/rst.
module tb_seq_update_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start32, start8;
  logic [31:0] ia32, ib32, ic32, id32;
  logic [7:0]  ia8, ib8, ic8, id8;
  logic [7:0]  iters32, iters8;
  logic [31:0] a32, b32, c32, d32;
  logic [7:0]  a8, b8, c8, d8;
  logic        busy32, done32, busy8, done8;
  logic [7:0]  pc32, pc8;
`ifdef SEQ_UPD_CONCURRENT_EN
  logic        mode32, mode8;
`endif

  seq_update_engine #(.W(32), .ITER_W(8)) dut32 (
    .clk(clk), .rst(rst), .start(start32),
    .init_a(ia32), .init_b(ib32), .init_c(ic32), .init_d(id32), .iters(iters32),
`ifdef SEQ_UPD_CONCURRENT_EN
    .mode(mode32),
`endif
    .a(a32), .b(b32), .c(c32), .d(d32), .busy(busy32), .done(done32), .pass_cnt(pc32)
  );

  seq_update_engine #(.W(8), .ITER_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .init_a(ia8), .init_b(ib8), .init_c(ic8), .init_d(id8), .iters(iters8),
`ifdef SEQ_UPD_CONCURRENT_EN
    .mode(mode8),
`endif
    .a(a8), .b(b8), .c(c8), .d(d8), .busy(busy8), .done(done8), .pass_cnt(pc8)
  );

  int checks = 0;
  int errors = 0;
  bit sel8 = 1'b0;

  logic [31:0] oa, ob, oc, od;
  logic        obusy, odone;
  logic [7:0]  opc;
  always_comb begin
    if (sel8) begin
      oa = {24'b0, a8}; ob = {24'b0, b8}; oc = {24'b0, c8}; od = {24'b0, d8};
      obusy = busy8; odone = done8; opc = pc8;
    end else begin
      oa = a32; ob = b32; oc = c32; od = d32;
      obusy = busy32; odone = done32; opc = pc32;
    end
  end

  typedef struct {
    logic [31:0] a, b, c, d;
    logic [7:0]  pc;
  } exp_t;
  exp_t sb[$];

  function automatic exp_t model(input logic [31:0] ia, ib, ic, id, input int n, input int w,
                                 input bit conc);
    logic [31:0] m, va, vb, vc, vd, na, nb, nc, nd;
    exp_t e;
    m  = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    va = ia & m; vb = ib & m; vc = ic & m; vd = id & m;
    for (int i = 0; i < n; i++) begin
      if (conc) begin
        na = (vb + vc) & m;
        nd = (va + vc) & m;
        nb = (va - 32'd3) & m;
        nc = (vb + 32'd10) & m;
        va = na; vb = nb; vc = nc; vd = nd;
      end else begin
        va = (vb + vc) & m;
        vd = (va + vc) & m;
        vb = (va - 32'd3) & m;
        vc = (vb + 32'd10) & m;
      end
    end
    e.a = va; e.b = vb; e.c = vc; e.d = vd; e.pc = n[7:0];
    return e;
  endfunction

  task automatic drive_start(input bit s8, input bit v, input logic [31:0] ia, ib, ic, id,
                             input logic [7:0] n, input bit conc);
    if (s8) begin
      start8 = v; ia8 = ia[7:0]; ib8 = ib[7:0]; ic8 = ic[7:0]; id8 = id[7:0]; iters8 = n;
`ifdef SEQ_UPD_CONCURRENT_EN
      mode8 = conc;
`endif
    end else begin
      start32 = v; ia32 = ia; ib32 = ib; ic32 = ic; id32 = id; iters32 = n;
`ifdef SEQ_UPD_CONCURRENT_EN
      mode32 = conc;
`endif
    end
    if (conc && !v) ; // mode is only meaningful together with start
  endtask

  // One accepted run: push expectation, walk the busy window, check done cycle and final values.
  task automatic run(input bit s8, input logic [31:0] ia, ib, ic, id, input int n,
                     input bit conc, input int poke_k, input string name);
    exp_t e;
    int   lat;
    bit   bad;
    sel8 = s8;
    lat  = conc ? n : 4 * n;
    drive_start(s8, 1'b1, ia, ib, ic, id, n[7:0], conc);
    sb.push_back(model(ia, ib, ic, id, n, s8 ? 8 : 32, conc));
    @(posedge clk); #1;
    bad = 1'b0;
    for (int k = 0; k < lat; k++) begin
      if (k == poke_k)
        drive_start(s8, 1'b1, $urandom, $urandom, $urandom, $urandom, 8'($urandom), 1'b0);
      else
        drive_start(s8, 1'b0, $urandom, $urandom, $urandom, $urandom, 8'($urandom), 1'b0);
      if (obusy !== 1'b1 || odone !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    drive_start(s8, 1'b0, $urandom, $urandom, $urandom, $urandom, 8'($urandom), 1'b0);
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s busy_window: busy/done not 1/0 on every cycle of edges 0..%0d", name, lat - 1);
    end
    checks++;
    if (odone !== 1'b1 || obusy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_timing: done=%b busy=%b after edge %0d, required done=1 busy=0",
               name, odone, obusy, lat);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard_empty: got nothing, required one expectation", name);
    end else begin
      e = sb.pop_front();
      if (oa !== e.a || ob !== e.b || oc !== e.c || od !== e.d || opc !== e.pc) begin
        errors++;
        $display("FAIL %s result: got a=%0d b=%0d c=%0d d=%0d pass_cnt=%0d, required a=%0d b=%0d c=%0d d=%0d pass_cnt=%0d",
                 name, oa, ob, oc, od, opc, e.a, e.b, e.c, e.d, e.pc);
      end
    end
    $display("txn %s: iters=%0d a=%0d b=%0d c=%0d d=%0d pass_cnt=%0d done_after_edge=%0d",
             name, n, oa, ob, oc, od, opc, lat);
    @(posedge clk); #1;
    checks++;
    if (odone !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse_width: done=%b one cycle later, required 0", name, odone);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_start(1'b0, 1'b0, 0, 0, 0, 0, 8'd0, 1'b0);
    drive_start(1'b1, 1'b0, 0, 0, 0, 0, 8'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({a32, b32, c32, d32} !== 128'd0 || pc32 !== 8'd0 || busy32 !== 1'b0 || done32 !== 1'b0 ||
        {a8, b8, c8, d8} !== 32'd0 || pc8 !== 8'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: a32=%0d b32=%0d c32=%0d d32=%0d pc=%0d busy=%b done=%b a8=%0d, required all 0",
               a32, b32, c32, d32, pc32, busy32, done32, a8);
    end
  endtask

  task automatic test_single_pass;
    run(1'b0, 32'd10, 32'd20, 32'd40, 32'd39, 1, 1'b0, -1, "iters1");
    checks++;
    if (a32 !== 32'd60 || d32 !== 32'd100 || b32 !== 32'd57 || c32 !== 32'd67 || pc32 !== 8'd1) begin
      errors++;
      $display("FAIL iters1_const: got a=%0d d=%0d b=%0d c=%0d pc=%0d, required 60 100 57 67 1",
               a32, d32, b32, c32, pc32);
    end
  endtask

  task automatic test_two_pass;
    run(1'b0, 32'd10, 32'd20, 32'd40, 32'd39, 2, 1'b0, -1, "iters2");
    checks++;
    if (a32 !== 32'd124 || d32 !== 32'd191 || b32 !== 32'd121 || c32 !== 32'd131 || pc32 !== 8'd2) begin
      errors++;
      $display("FAIL iters2_const: got a=%0d d=%0d b=%0d c=%0d pc=%0d, required 124 191 121 131 2",
               a32, d32, b32, c32, pc32);
    end
  endtask

  task automatic test_zero_iters;
    run(1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 0, 1'b0, -1, "iters0");
    checks++;
    if (a32 !== 32'd1 || b32 !== 32'd2 || c32 !== 32'd3 || d32 !== 32'd4 || pc32 !== 8'd0) begin
      errors++;
      $display("FAIL iters0_const: got a=%0d b=%0d c=%0d d=%0d pc=%0d, required 1 2 3 4 0",
               a32, b32, c32, d32, pc32);
    end
  endtask

  task automatic test_wrap_and_ignored_start;
    run(1'b1, 32'd0, 32'd200, 32'd100, 32'd0, 1, 1'b0, 1, "w8_wrap_poke_sd");
    checks++;
    if (a8 !== 8'd44 || d8 !== 8'd144 || b8 !== 8'd41 || c8 !== 8'd51) begin
      errors++;
      $display("FAIL w8_wrap_const: got a=%0d d=%0d b=%0d c=%0d, required 44 144 41 51", a8, d8, b8, c8);
    end
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    sel8 = 1'b0;
    drive_start(1'b0, 1'b1, 32'd10, 32'd20, 32'd40, 32'd39, 8'd3, 1'b0);
    @(posedge clk); #1;
    drive_start(1'b0, 1'b0, 0, 0, 0, 0, 8'd0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (a32 !== 32'd60 || d32 !== 32'd100 || busy32 !== 1'b1) begin
      errors++;
      $display("FAIL midrun_pre_reset: got a=%0d d=%0d busy=%b, required 60 100 1", a32, d32, busy32);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a32, b32, c32, d32} !== 128'd0 || pc32 !== 8'd0 || busy32 !== 1'b0 || done32 !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async_reset: got a=%0d b=%0d c=%0d d=%0d busy=%b done=%b, required all 0",
               a32, b32, c32, d32, busy32, done32);
    end
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done32 !== 1'b0 || busy32 !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrun_no_done: done or busy seen high after abort, required both 0");
    end
    run(1'b0, 32'd5, 32'd6, 32'd7, 32'd8, 2, 1'b0, -1, "after_abort");
  endtask

  task automatic test_back_to_back;
    run(1'b0, 32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'h8000_0005, 32'd9, 3, 1'b0, -1, "b2b_0");
    for (int i = 1; i <= 4; i++)
      run(1'b0, $urandom, $urandom, $urandom, $urandom, $urandom_range(1, 4), 1'b0, -1,
          $sformatf("b2b_%0d", i));
    run(1'b1, $urandom, $urandom, $urandom, $urandom, 3, 1'b0, 6, "b2b_w8_poke");
  endtask

`ifdef SEQ_UPD_CONCURRENT_EN
  task automatic test_concurrent;
    run(1'b0, 32'd10, 32'd20, 32'd40, 32'd39, 1, 1'b1, -1, "conc_iters1");
    checks++;
    if (a32 !== 32'd60 || d32 !== 32'd50 || b32 !== 32'd7 || c32 !== 32'd30) begin
      errors++;
      $display("FAIL conc_const: got a=%0d d=%0d b=%0d c=%0d, required 60 50 7 30", a32, d32, b32, c32);
    end
    run(1'b0, $urandom, $urandom, $urandom, $urandom, 5, 1'b1, -1, "conc_iters5");
    run(1'b1, 32'd0, 32'd200, 32'd100, 32'd0, 3, 1'b1, -1, "conc_w8");
    run(1'b0, 32'd10, 32'd20, 32'd40, 32'd39, 1, 1'b0, -1, "conc_mode0");
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_single_pass;
    test_two_pass;
    test_zero_iters;
    test_wrap_and_ignored_start;
    test_reset_mid_run;
    test_back_to_back;
`ifdef SEQ_UPD_CONCURRENT_EN
    test_concurrent;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
